// File: rtl/spidergon_ni_depacketizer.sv
// Ejection-side network interface for one Spidergon node: reassembles ejected flits
// into whole packets and hands each one to the local CPU as a single wide word.
module spidergon_ni_depacketizer #(
    parameter int NUM_OF_NODES            = 8,
    parameter int FLIT_DATA_WIDTH         = 16,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int NODE_IDENTIFIER         = 0,
    parameter int MAX_DATA_FLITS          = 4,
    localparam int DEST_W = $clog2(NUM_OF_NODES),
    localparam int FTW    = FLIT_DATA_WIDTH + 2,
    localparam int VC_W   = $clog2(NUM_OF_VIRTUAL_CHANNELS),
    localparam int LEN_W  = $clog2(MAX_DATA_FLITS + 1),
    localparam int DATA_W = MAX_DATA_FLITS * FLIT_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FTW-1:0]    flit_in,
    input  logic              flit_in_valid,
    output logic              flit_in_ready,
    output logic [DATA_W-1:0] cpu_data,
    output logic [LEN_W-1:0]  cpu_len,
    output logic [VC_W-1:0]   cpu_vc,
    output logic              cpu_is_header,
    output logic              cpu_data_valid,
    input  logic              cpu_data_ready,
    output logic              misroute_err,
    output logic              protocol_err,
    output logic [15:0]       pkt_count
);

    localparam int HP_W = FLIT_DATA_WIDTH - VC_W - DEST_W;

    typedef enum logic [1:0] {
        T_TAIL   = 2'b00,
        T_HEAD   = 2'b01,
        T_BODY   = 2'b10,
        T_HEADER = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DROP,
        DELIVER
    } state_t;

    state_t     state;
    logic [LEN_W-1:0] count;

    flit_type_t ftype;
    logic [VC_W-1:0]   fvc;
    logic [DEST_W-1:0] fdest;
    logic [FLIT_DATA_WIDTH-1:0] payload;
    logic [HP_W-1:0]   hdr_payload;
    logic dest_ok;
    logic is_start;

    always_comb begin
        ftype       = flit_type_t'(flit_in[FTW-1 -: 2]);
        fvc         = flit_in[FTW-3 -: VC_W];
        fdest       = flit_in[FTW-3-VC_W -: DEST_W];
        payload     = flit_in[FLIT_DATA_WIDTH-1:0];
        hdr_payload = flit_in[HP_W-1:0];
        dest_ok     = (fdest == DEST_W'(NODE_IDENTIFIER));
        is_start    = (ftype == T_HEAD) || (ftype == T_HEADER);
    end

    assign flit_in_ready = (state != DELIVER) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            cpu_data       <= '0;
            cpu_len        <= '0;
            cpu_vc         <= '0;
            cpu_is_header  <= 1'b0;
            cpu_data_valid <= 1'b0;
            misroute_err   <= 1'b0;
            protocol_err   <= 1'b0;
            pkt_count      <= '0;
        end else begin
            misroute_err <= 1'b0;
            protocol_err <= 1'b0;
            if (state == DELIVER) begin
                if (cpu_data_ready) begin
                    state          <= IDLE;
                    cpu_data_valid <= 1'b0;
                    pkt_count      <= pkt_count + 16'd1;
                end
            end else if (flit_in_valid) begin
                // A new packet start is handled identically from IDLE, COLLECT and DROP;
                // only COLLECT flags the abandoned packet.
                if (is_start) begin
                    if (state == COLLECT) protocol_err <= 1'b1;
                    if (!dest_ok) begin
                        misroute_err <= 1'b1;
                        state        <= (ftype == T_HEAD) ? DROP : IDLE;
                    end else if (ftype == T_HEADER) begin
                        cpu_data       <= DATA_W'(hdr_payload);
                        cpu_len        <= LEN_W'(1);
                        cpu_is_header  <= 1'b1;
                        cpu_vc         <= fvc;
                        cpu_data_valid <= 1'b1;
                        state          <= DELIVER;
                    end else begin
                        cpu_vc   <= fvc;
                        count    <= '0;
                        cpu_data <= '0;
                        state    <= COLLECT;
                    end
                end else begin
                    case (state)
                        IDLE: protocol_err <= 1'b1;
                        COLLECT: begin
                            if (ftype == T_BODY) begin
                                if (count == LEN_W'(MAX_DATA_FLITS - 1)) begin
                                    protocol_err <= 1'b1;
                                    state        <= DROP;
                                end else begin
                                    cpu_data[int'(count)*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH] <= payload;
                                    count <= count + LEN_W'(1);
                                end
                            end else begin
                                cpu_data[int'(count)*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH] <= payload;
                                cpu_len        <= count + LEN_W'(1);
                                cpu_is_header  <= 1'b0;
                                cpu_data_valid <= 1'b1;
                                state          <= DELIVER;
                            end
                        end
                        DROP: if (ftype == T_TAIL) state <= IDLE;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/spidergon_ni_depacketizer.md
Name: spidergon_ni_depacketizer

Overview:
Ejection-side network interface for one Spidergon node. It accepts the flit stream that a node delivers to its local CPU and reassembles it into whole packets. It checks the destination and flit-type ordering, then presents each packet as one wide word to the user CPU module over a valid/ready handshake. It is the receiving end of the packet format that nodes inject: 2-bit type, then VC, then destination, then payload.

Parameters:
NUM_OF_NODES, 8, ring size; DEST_W = $clog2(NUM_OF_NODES).
FLIT_DATA_WIDTH, 16, flit payload width; FTW = FLIT_DATA_WIDTH+2.
NUM_OF_VIRTUAL_CHANNELS, 2, VCs per port; VC_W = $clog2(NUM_OF_VIRTUAL_CHANNELS).
NODE_IDENTIFIER, 0, this node's address.
MAX_DATA_FLITS, 4, maximum body+tail flits per packet; LEN_W = $clog2(MAX_DATA_FLITS+1).

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
flit_in  in  FTW  ejected flit.
flit_in_valid  in  1  flit_in is valid.
flit_in_ready  out  1  block accepts a flit this cycle.
cpu_data  out  MAX_DATA_FLITS*FLIT_DATA_WIDTH  word i = cpu_data[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH].
cpu_len  out  LEN_W  number of valid words.
cpu_vc  out  VC_W  VC taken from the head flit.
cpu_is_header  out  1  packet was a single HEADER flit.
cpu_data_valid  out  1  packet available.
cpu_data_ready  in  1  CPU consumes the packet.
misroute_err  out  1  one-cycle pulse: packet destination != NODE_IDENTIFIER.
protocol_err  out  1  one-cycle pulse: illegal flit order or overflow.
pkt_count  out  16  packets delivered; wraps.

Behaviour:
- Flit fields: type = flit_in[FTW-1 -: 2]; vc = next VC_W bits; dest = next DEST_W bits; header payload = low HP_W = FLIT_DATA_WIDTH-VC_W-DEST_W bits.
- Type codes: 01 HEAD, 11 HEADER (single flit), 10 BODY, 00 TAIL.
- BODY and TAIL flits carry the full FLIT_DATA_WIDTH payload. A HEAD flit carries no data words.
- Transfer occurs when flit_in_valid && flit_in_ready. flit_in_ready = (state != DELIVER) && !reset.
- Reset (async): state IDLE. cpu_data, cpu_len, cpu_vc, cpu_is_header, cpu_data_valid, error pulses, pkt_count and word count all 0.
- Reset mid-packet or mid-delivery discards the packet with no error pulse.
- State IDLE:
  - HEADER with matching dest: word0 = zero-extended header payload, len=1, is_header=1, latch vc, go to DELIVER.
  - HEADER with mismatched dest: misroute_err pulse, stay in IDLE.
  - HEAD with matching dest: latch vc, count=0, clear words, go to COLLECT.
  - HEAD with mismatched dest: misroute_err pulse, go to DROP.
  - BODY or TAIL: protocol_err pulse, discard, stay in IDLE.
- State COLLECT:
  - BODY with count<MAX_DATA_FLITS-1: word[count] = payload, count++.
  - BODY with count==MAX_DATA_FLITS-1: protocol_err pulse (overflow), go to DROP.
  - TAIL with count<MAX_DATA_FLITS: word[count] = payload, len=count+1, is_header=0, go to DELIVER.
  - HEAD or HEADER: protocol_err pulse, abandon the current packet, then process the new flit exactly as IDLE would in the same cycle.
- State DROP:
  - BODY: discard.
  - TAIL: discard, go to IDLE.
  - HEAD or HEADER: processed as in IDLE, with no extra error pulse.
- State DELIVER:
  - cpu_data_valid=1; all cpu_* outputs are stable; flit_in_ready=0.
  - On cpu_data_ready: go to IDLE, pkt_count++ (wraps at 16'hFFFF to 0), cpu_data_valid drops the next cycle.
- Latency: tail (or HEADER) accepted at cycle N -> cpu_data_valid=1 at N+1. The earliest next flit is accepted in the cycle after the CPU handshake.
- Unused words above cpu_len read as 0.
- Error pulses are registered: asserted in the cycle after the offending flit, high for exactly 1 cycle.

Test Plan:
1. NODE_IDENTIFIER=3, 8 nodes, 16-bit data, 2 VC. HEADER flit_in=18'h3BABC, cpu_data_ready=1 -> next cycle cpu_data_valid=1, word0=0x0ABC, cpu_len=1, cpu_vc=1, cpu_is_header=1; following cycle valid=0, pkt_count=1.
2. Send HEAD 18'h13000, BODY 18'h21111, BODY 18'h22222, TAIL 18'h03333 on back-to-back cycles -> words 0x1111/0x2222/0x3333/0x0000, cpu_len=3, cpu_vc=0. Hold cpu_data_ready=0 for 5 cycles -> outputs stable, flit_in_ready=0 for all 5.
3. HEAD to dest 5 (18'h15000), BODY, TAIL -> misroute_err pulse 1 cycle after the HEAD; the remaining flits are consumed; no cpu_data_valid; pkt_count unchanged.
4. HEAD, then 4 BODY flits (MAX_DATA_FLITS=4) -> protocol_err 1 cycle after the 4th BODY; the following TAIL is dropped; a new HEADER afterwards is delivered normally.
5. Lone BODY 18'h21234 in IDLE -> protocol_err pulse, nothing delivered. HEAD then HEADER 18'h3BABC -> protocol_err pulse, and the HEADER packet is delivered with word0=0x0ABC.
6. Assert reset during COLLECT after 2 BODY flits -> outputs immediately 0 and flit_in_ready=0 while reset is high. After release, a fresh HEAD/TAIL packet delivers with cpu_len=1.
